// File: rtl/cdc_2phase_sched_pkg.sv
// Shared types and helpers for the two-phase CDC source-side scheduler.
package cdc_2phase_sched_pkg;

    typedef enum logic [2:0] {
        ST_ARB,
        ST_DRAIN,
        ST_CLEAR,
        ST_WAIT_HI,
        ST_WAIT_LO
    } sched_state_e;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdc_2phase_sched_rr.sv
// Rotate-priority selector: first valid requester at or after the pointer, wrapping.
module cdc_2phase_sched_rr #(
    parameter int unsigned NumIn = 4,
    parameter int unsigned IdxW  = 2
) (
    input  logic [NumIn-1:0] valid_i,
    input  logic [IdxW-1:0]  ptr_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             any_valid_o
);

    int unsigned     sum;
    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        sum   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            sum = 32'(ptr_i) + k;
            if (sum >= NumIn) begin
                sum = sum - NumIn;
            end
            cand = IdxW'(sum);
            if (!found && valid_i[cand]) begin
                idx_o = cand;
                found = 1'b1;
            end
        end
    end

    assign any_valid_o = |valid_i;

endmodule

// File: rtl/cdc_2phase_src_sched.sv
// Round-robin, lock-holding scheduler for a clearable two-phase CDC source port,
// sequencing local and far-side clear requests around in-flight transfers.
module cdc_2phase_src_sched
    import cdc_2phase_sched_pkg::*;
#(
    parameter int unsigned NumIn       = 4,
    parameter type         T           = logic,
    parameter int unsigned DrainCycles = 16,
    parameter int unsigned IdxW        = idx_width(NumIn)
) (
    input  logic             src_clk_i,
    input  logic             src_rst_ni,
    input  logic             clear_req_i,
    output logic             clear_busy_o,
    output logic             clear_done_o,
    output logic             aborted_o,
    input  logic [NumIn-1:0] in_valid_i,
    output logic [NumIn-1:0] in_ready_o,
    input  T                 in_data_i [NumIn],
    output logic             cdc_valid_o,
    input  logic             cdc_ready_i,
    output T                 cdc_data_o,
    output logic [IdxW-1:0]  cdc_idx_o,
    output logic             cdc_clear_o,
    input  logic             cdc_clear_pending_i
);

    localparam int unsigned CntW = idx_width(DrainCycles);

    sched_state_e    state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lidx_q, lidx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            aborted_q, aborted_d;
    logic            done_q, done_d;

    logic [IdxW-1:0] rr_idx;
    logic            any_valid;
    logic [IdxW-1:0] grant_c;
    logic [IdxW-1:0] ptr_next_c;
    logic            valid_c;
    logic            hs_c;
    logic            clear_c;

    cdc_2phase_sched_rr #(
        .NumIn (NumIn),
        .IdxW  (IdxW)
    ) u_rr (
        .valid_i     (in_valid_i),
        .ptr_i       (ptr_q),
        .idx_o       (rr_idx),
        .any_valid_o (any_valid)
    );

    // A held lock overrides the rotating selection until its handshake.
    assign grant_c    = lock_q ? lidx_q : rr_idx;
    assign ptr_next_c = (grant_c == IdxW'(NumIn - 1)) ? '0 : grant_c + IdxW'(1);

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            lock_q    <= 1'b0;
            lidx_q    <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lidx_q    <= lidx_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        lock_d    = lock_q;
        lidx_d    = lidx_q;
        cnt_d     = cnt_q;
        aborted_d = 1'b0;
        done_d    = 1'b0;
        valid_c   = 1'b0;
        hs_c      = 1'b0;
        clear_c   = 1'b0;

        unique case (state_q)
            ST_ARB: begin
                if (cdc_clear_pending_i) begin
                    // Far side started a clear: drop everything and follow it.
                    aborted_d = lock_q;
                    lock_d    = 1'b0;
                    state_d   = ST_WAIT_LO;
                end else begin
                    if (lock_q) begin
                        valid_c = in_valid_i[lidx_q];
                    end else begin
                        valid_c = any_valid & ~clear_req_i;
                    end
                    hs_c = valid_c & cdc_ready_i;
                    if (hs_c) begin
                        ptr_d  = ptr_next_c;
                        lock_d = 1'b0;
                    end else if (valid_c) begin
                        lock_d = 1'b1;
                        lidx_d = grant_c;
                    end
                    if (clear_req_i) begin
                        if (lock_q && !hs_c) begin
                            state_d = ST_DRAIN;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_CLEAR;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (cdc_clear_pending_i) begin
                    aborted_d = lock_q;
                    lock_d    = 1'b0;
                    state_d   = ST_WAIT_LO;
                end else begin
                    valid_c = in_valid_i[lidx_q];
                    hs_c    = valid_c & cdc_ready_i;
                    if (hs_c) begin
                        ptr_d   = ptr_next_c;
                        lock_d  = 1'b0;
                        state_d = ST_CLEAR;
                    end else if (cnt_q == CntW'(DrainCycles - 1)) begin
                        aborted_d = 1'b1;
                        lock_d    = 1'b0;
                        state_d   = ST_CLEAR;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            ST_CLEAR: begin
                clear_c = 1'b1;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (cdc_clear_pending_i) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!cdc_clear_pending_i) begin
                    state_d = ST_ARB;
                    ptr_d   = '0;
                    lock_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    assign cdc_valid_o  = valid_c;
    assign cdc_clear_o  = clear_c;
    assign cdc_idx_o    = grant_c;
    assign cdc_data_o   = in_data_i[grant_c];
    assign in_ready_o   = hs_c ? (NumIn'(1) << grant_c) : '0;
    assign clear_busy_o = (state_q != ST_ARB);
    assign clear_done_o = done_q;
    assign aborted_o    = aborted_q;

endmodule

// File: tb/tb_cdc_2phase_src_sched.sv
// Directed scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_cdc_2phase_src_sched;

    localparam int unsigned N = 4;
    localparam int unsigned D = 16;
    typedef logic [7:0] data_t;

    localparam int M_ARB   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_CLEAR = 2;
    localparam int M_WHI   = 3;
    localparam int M_WLO   = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear_req;
    logic         clear_busy;
    logic         clear_done;
    logic         aborted;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    data_t        in_data [N];
    logic         cdc_valid;
    logic         cdc_ready;
    data_t        cdc_data;
    logic [1:0]   cdc_idx;
    logic         cdc_clear;
    logic         pend;

    always #5 clk = ~clk;

    cdc_2phase_src_sched #(
        .NumIn       (N),
        .T           (data_t),
        .DrainCycles (D)
    ) dut (
        .src_clk_i           (clk),
        .src_rst_ni          (rst_n),
        .clear_req_i         (clear_req),
        .clear_busy_o        (clear_busy),
        .clear_done_o        (clear_done),
        .aborted_o           (aborted),
        .in_valid_i          (in_valid),
        .in_ready_o          (in_ready),
        .in_data_i           (in_data),
        .cdc_valid_o         (cdc_valid),
        .cdc_ready_i         (cdc_ready),
        .cdc_data_o          (cdc_data),
        .cdc_idx_o           (cdc_idx),
        .cdc_clear_o         (cdc_clear),
        .cdc_clear_pending_i (pend)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_mode, m_ptr, m_lidx, m_drain_used;
    bit m_lock, m_done, m_abort;
    bit e_valid, e_clear, e_hs;
    int e_grant;
    logic [N-1:0] e_ready;

    // Observed values captured on the falling edge
    logic       obs_valid, obs_clear, obs_abort, obs_done;
    logic [1:0] obs_idx;
    logic [N-1:0] obs_ready;

    // Random traffic bookkeeping
    bit    req_v [N];
    data_t req_d [N];
    int    pend_hold;
    int    stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_ARB; m_ptr = 0; m_lidx = 0; m_drain_used = 0;
        m_lock = 0; m_done = 0; m_abort = 0;
    endtask

    task automatic model_comb();
        int g;
        g = 0;
        if (m_lock) begin
            g = m_lidx;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (in_valid[2'((m_ptr + k) % N)]) g = (m_ptr + k) % N;
            end
        end
        e_grant = g;
        case (m_mode)
            M_ARB:   e_valid = pend ? 1'b0 : (m_lock ? in_valid[2'(m_lidx)] : ((|in_valid) && !clear_req));
            M_DRAIN: e_valid = !pend && in_valid[2'(m_lidx)];
            default: e_valid = 1'b0;
        endcase
        e_clear = (m_mode == M_CLEAR);
        e_hs    = e_valid && cdc_ready;
        e_ready = e_hs ? N'(1 << g) : '0;
    endtask

    task automatic model_update();
        bit was_locked;
        was_locked = m_lock;
        m_done  = 0;
        m_abort = 0;
        case (m_mode)
            M_ARB: begin
                if (pend) begin
                    m_abort = m_lock; m_lock = 0; m_mode = M_WLO;
                end else begin
                    if (e_hs) begin
                        m_ptr = (e_grant + 1) % N; m_lock = 0;
                    end else if (e_valid) begin
                        m_lock = 1; m_lidx = e_grant;
                    end
                    if (clear_req) begin
                        if (was_locked && !e_hs) begin
                            m_mode = M_DRAIN; m_drain_used = 0;
                        end else begin
                            m_mode = M_CLEAR;
                        end
                    end
                end
            end
            M_DRAIN: begin
                m_drain_used++;
                if (pend) begin
                    m_abort = 1; m_lock = 0; m_mode = M_WLO;
                end else if (e_hs) begin
                    m_ptr = (e_grant + 1) % N; m_lock = 0; m_mode = M_CLEAR;
                end else if (m_drain_used == D) begin
                    m_abort = 1; m_lock = 0; m_mode = M_CLEAR;
                end
            end
            M_CLEAR: m_mode = M_WHI;
            M_WHI:   if (pend) m_mode = M_WLO;
            default: begin
                if (!pend) begin
                    m_mode = M_ARB; m_ptr = 0; m_lock = 0; m_done = 1;
                end
            end
        endcase
    endtask

    task automatic check_model();
        chk("cdc_valid", 32'(obs_valid), 32'(e_valid));
        chk("cdc_clear", 32'(obs_clear), 32'(e_clear));
        chk("in_ready", 32'(obs_ready), 32'(e_ready));
        chk("clear_busy", 32'(clear_busy), 32'(m_mode != M_ARB));
        chk("clear_done", 32'(obs_done), 32'(m_done));
        chk("aborted", 32'(obs_abort), 32'(m_abort));
        if (e_valid) begin
            chk("cdc_idx", 32'(obs_idx), 32'(e_grant));
            chk("cdc_data", 32'(cdc_data), 32'(in_data[2'(e_grant)]));
        end
    endtask

    // One clock: check at the falling edge, advance the model after the rising edge.
    task automatic cycle();
        @(negedge clk);
        obs_valid = cdc_valid; obs_clear = cdc_clear; obs_abort = aborted;
        obs_done  = clear_done; obs_idx = cdc_idx; obs_ready = in_ready;
        model_comb();
        check_model();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid"}, 32'(cdc_valid), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_clear"}, 32'(cdc_clear), 32'd0);
        chk({tag, "_busy"}, 32'(clear_busy), 32'd0);
        chk({tag, "_done"}, 32'(clear_done), 32'd0);
        chk({tag, "_aborted"}, 32'(aborted), 32'd0);
        chk({tag, "_idx"}, 32'(cdc_idx), 32'd0);
    endtask

    initial begin
        int n_valid, n_abort, n_clear, n_done, n_ready;

        rst_n = 1'b0; clear_req = 0; in_valid = '0; cdc_ready = 0; pend = 0;
        for (int i = 0; i < N; i++) in_data[i] = 8'h00;
        model_reset();
        #1;
        check_idle_outputs("reset");
        chk("reset_data", 32'(cdc_data), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = 8'(8'h10 * i + 8'h05);

        // Rotation with all requesters valid and the CDC always ready
        in_valid = 4'hf; cdc_ready = 1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rot_idx", 32'(obs_idx), 32'(k % N));
            chk("rot_ready", 32'(obs_ready), 32'(1 << (k % N)));
        end
        in_valid = '0;

        // Lock holds requester 1 while requester 0 joins
        in_valid = 4'b0010; cdc_ready = 0;
        cycle(); chk("lock_idx1", 32'(obs_idx), 32'd1);
        in_valid = 4'b0011;
        cycle(); chk("lock_idx2", 32'(obs_idx), 32'd1);
        cycle(); chk("lock_idx3", 32'(obs_idx), 32'd1);
        cdc_ready = 1;
        cycle(); chk("lock_hs_idx", 32'(obs_idx), 32'd1);
        chk("lock_hs_ready", 32'(obs_ready), 32'b0010);
        in_valid = 4'b0001;
        cycle(); chk("lock_wrap_idx", 32'(obs_idx), 32'd0);
        in_valid = '0; cdc_ready = 0;

        // Clean clear from idle
        clear_req = 1;
        cycle(); chk("clr_req_cycle", 32'(obs_clear), 32'd0);
        clear_req = 0;
        cycle(); chk("clr_pulse", 32'(obs_clear), 32'd1);
        cycle(); chk("clr_after", 32'(obs_clear), 32'd0);
        n_done = 0; n_clear = 0;
        for (int k = 0; k < 9; k++) begin
            pend = (k < 5);
            cycle();
            n_done += int'(obs_done); n_clear += int'(obs_clear);
        end
        chk("clr_done_count", 32'(n_done), 32'd1);
        chk("clr_no_reissue", 32'(n_clear), 32'd0);
        in_valid = 4'hf; cdc_ready = 1;
        cycle(); chk("clr_grant_from0", 32'(obs_idx), 32'd0);
        in_valid = '0; cdc_ready = 0;

        // Drain timeout abort on a stuck locked transfer
        in_valid = 4'b0100;
        cycle();
        clear_req = 1;
        cycle();
        clear_req = 0;
        n_valid = 0; n_abort = 0; n_clear = 0; n_ready = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_valid += int'(obs_valid); n_abort += int'(obs_abort);
            n_clear += int'(obs_clear); n_ready += int'(obs_ready != '0);
        end
        chk("drain_valid_cycles", 32'(n_valid), 32'(D));
        chk("drain_abort_count", 32'(n_abort), 32'd1);
        chk("drain_clear_count", 32'(n_clear), 32'd1);
        chk("drain_no_ready", 32'(n_ready), 32'd0);
        pend = 1; cycle();
        pend = 0; cycle();
        cdc_ready = 1;
        cycle(); chk("drain_retry_idx", 32'(obs_idx), 32'd2);
        chk("drain_retry_ready", 32'(obs_ready), 32'b0100);
        in_valid = '0; cdc_ready = 0;

        // Far-side clear during a locked transfer, local clear absorbed
        in_valid = 4'b1000;
        cycle();
        pend = 1; clear_req = 1;
        cycle(); chk("far_valid_drop", 32'(obs_valid), 32'd0);
        clear_req = 0;
        n_abort = 0; n_clear = 0; n_done = 0;
        for (int k = 0; k < 7; k++) begin
            pend = (k < 3);
            cycle();
            n_abort += int'(obs_abort); n_clear += int'(obs_clear); n_done += int'(obs_done);
        end
        chk("far_abort_count", 32'(n_abort), 32'd1);
        chk("far_no_clear", 32'(n_clear), 32'd0);
        chk("far_done_count", 32'(n_done), 32'd1);
        in_valid = '0;

        // Asynchronous reset while waiting for the far side
        clear_req = 1; cycle();
        clear_req = 0; cycle(); cycle();
        chk("pre_rst_busy", 32'(clear_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        in_valid = 4'hf; cdc_ready = 1;
        cycle(); chk("rst_grant_from0", 32'(obs_idx), 32'd0);
        in_valid = '0; cdc_ready = 0;

        // Randomized traffic
        for (int i = 0; i < N; i++) begin req_v[i] = 0; req_d[i] = '0; end
        pend_hold = 0; stall = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] && ($urandom % 3 == 0)) begin
                    req_v[i] = 1; req_d[i] = 8'($urandom);
                end
                in_valid[i] = req_v[i]; in_data[i] = req_d[i];
            end
            if (stall == 0 && ($urandom % 100 == 0)) stall = 30;
            cdc_ready = (stall > 0) ? 1'b0 : 1'($urandom % 2);
            if (stall > 0) stall--;
            clear_req = ($urandom % 25 == 0);
            if (pend_hold == 0 && ((m_mode == M_WHI && $urandom % 3 == 0) || ($urandom % 80 == 0)))
                pend_hold = 1 + int'($urandom % 5);
            pend = (pend_hold > 0);
            if (pend_hold > 0) pend_hold--;
            cycle();
            for (int i = 0; i < N; i++) if (e_ready[i]) req_v[i] = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
